prog_logic_gate: RTL and testbench

- Run-time programmable N-input logic gate; the sequential successor to the fixed-function 3-input truth-table gates.
- Holds a 2^N_IN-bit truth table that is reloaded serially through a valid/ready handshake.
- Evaluates the inputs against the table and drives a registered, debounced output.
- Used wherever a gate function must change without resynthesis, and in benches that sweep many truth tables.

---
 rtl/prog_logic_pkg.sv | 15 +
 rtl/prog_logic_debounce.sv | 41 ++++
 rtl/prog_logic_gate.sv | 119 +++++++++++
 tb/tb_prog_logic_gate.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_logic_pkg.sv
// Shared types and helpers for the programmable logic gate family.
package prog_logic_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [63:0] DEFAULT_TABLE = 64'h28;

  function automatic int tbl_width(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/prog_logic_debounce.sv
// Registered output that follows a lookup value only after it has differed
// from the current output for HOLD_CYCLES consecutive enabled cycles.
module prog_logic_debounce
  import prog_logic_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic lookup,
  output logic out
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  logic [HW-1:0] hold_cnt;

  // Disabled cycles freeze both the output and the running count.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      out      <= 1'b0;
    end else if (clr) begin
      hold_cnt <= '0;
    end else if (en) begin
      if (lookup != out) begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          out      <= lookup;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/prog_logic_gate.sv
// Run-time programmable N-input gate with serially loaded truth table and
// debounced output. Define PROG_LOGIC_PARITY_EN for a trailing parity bit.
module prog_logic_gate
  import prog_logic_pkg::*;
#(
  parameter int          N_IN        = 3,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [63:0] RESET_TABLE = DEFAULT_TABLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            busy,
  output logic            out
`ifdef PROG_LOGIC_PARITY_EN
  ,
  output logic            cfg_err
`endif
);

  localparam int TW = tbl_width(N_IN);
  localparam int CW = $clog2(TW) + 1;
`ifdef PROG_LOGIC_PARITY_EN
  localparam int NBITS = TW + 1;
`else
  localparam int NBITS = TW;
`endif
  localparam logic [TW-1:0] RST_TBL = RESET_TABLE[TW-1:0];

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q;
  logic [TW-1:0] shadow_q, shadow_nxt, tbl_q;
  logic          accept, last_bit, par_ok, lookup;

  assign accept   = cfg_valid && cfg_ready && !cfg_start;
  assign last_bit = accept && (bit_cnt_q == CW'(NBITS - 1));
  assign lookup   = tbl_q[in];

`ifdef PROG_LOGIC_PARITY_EN
  // Even parity: the trailing bit must cancel the XOR of all table bits.
  assign par_ok = (cfg_bit == ^shadow_q);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    shadow_nxt = shadow_q;
    if (bit_cnt_q < CW'(TW)) shadow_nxt[bit_cnt_q[CW-2:0]] = cfg_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_start) state_d = LOAD;
      LOAD:    if (last_bit)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    busy      = (state_q == LOAD);
    cfg_ready = (state_q == LOAD);
  end

  // cfg_start restarts the load from row 0 whether idle or mid-load.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      tbl_q     <= RST_TBL;
      cfg_done  <= 1'b0;
`ifdef PROG_LOGIC_PARITY_EN
      cfg_err   <= 1'b0;
`endif
    end else begin
      cfg_done <= 1'b0;
`ifdef PROG_LOGIC_PARITY_EN
      cfg_err  <= 1'b0;
`endif
      if (cfg_start) begin
        bit_cnt_q <= '0;
        shadow_q  <= '0;
      end else if (accept) begin
        shadow_q  <= shadow_nxt;
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (last_bit) begin
          bit_cnt_q <= '0;
          cfg_done  <= par_ok;
          if (par_ok) tbl_q <= shadow_nxt;
`ifdef PROG_LOGIC_PARITY_EN
          cfg_err   <= !par_ok;
`endif
        end
      end
    end
  end

  prog_logic_debounce #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == RUN),
    .clr   (last_bit),
    .lookup(lookup),
    .out   (out)
  );

endmodule

// File: tb/tb_prog_logic_gate.sv
// Self-checking bench for prog_logic_gate: directed scenarios plus random
// table loads and input traffic compared against a behavioural model.
module tb_prog_logic_gate;

  localparam int HOLD = 2;
`ifdef PROG_LOGIC_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam logic [7:0] RST_TBL = 8'h28;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] gin = 3'd0;
  logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic       cfg_ready, cfg_done, busy, out;
`ifdef PROG_LOGIC_PARITY_EN
  logic       cfg_err;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // behavioural model state
  logic [7:0] m_tbl, m_sh;
  logic       m_load, m_out, m_done, m_err, m_pbit;
  int         m_cnt;
  logic       hist [HOLD];

  prog_logic_gate #(.N_IN(3), .HOLD_CYCLES(HOLD), .RESET_TABLE(64'h28)) dut (
    .clk      (clk),
    .reset    (rst),
    .in       (gin),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .busy     (busy),
    .out      (out)
`ifdef PROG_LOGIC_PARITY_EN
    ,
    .cfg_err  (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Output changes only once the last HOLD run-cycle lookups all disagree with it.
  task automatic model_edge();
    logic lk, diff, ok;
    if (rst) begin
      m_tbl = RST_TBL; m_load = 0; m_out = 0; m_done = 0; m_err = 0; m_cnt = 0;
      for (int i = 0; i < HOLD; i++) hist[i] = 1'b0;
      return;
    end
    m_done = 0; m_err = 0;
    if (!m_load) begin
      lk = m_tbl[gin];
      for (int i = HOLD - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = lk;
      diff = 1'b1;
      for (int i = 0; i < HOLD; i++) if (hist[i] == m_out) diff = 1'b0;
      if (diff) m_out = lk;
      if (cfg_start) begin m_load = 1; m_cnt = 0; end
    end else if (cfg_start) begin
      m_cnt = 0;
    end else if (cfg_valid) begin
      if (m_cnt < 8) m_sh[m_cnt] = cfg_bit;
      else m_pbit = cfg_bit;
      m_cnt++;
      if (m_cnt == NB) begin
        m_load = 0;
        ok = (NB == 8) || (m_pbit == ^m_sh);
        if (ok) begin m_tbl = m_sh; m_done = 1; end
        else m_err = 1;
        for (int i = 0; i < HOLD; i++) hist[i] = m_out;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    if (cfg_done === 1'b1) done_cnt++;
    chk("out", out, m_out);
    chk("busy", busy, m_load);
    chk("cfg_ready", cfg_ready, m_load);
    chk("cfg_done", cfg_done, m_done);
`ifdef PROG_LOGIC_PARITY_EN
    chk("cfg_err", cfg_err, m_err);
`endif
  endtask

  // Start a load and send nbits bits (data rows then parity) with random gaps.
  task automatic load_bits(input logic [7:0] t, input int nbits, input logic pbit, input int gapmax);
    logic frz;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    frz = out;
    for (int i = 0; i < nbits; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        gin = 3'($urandom);
        cfg_valid = 1'b0;
        cyc();
        chk("frozen", out, frz);
      end
      cfg_valid = 1'b1;
      cfg_bit   = (i < 8) ? t[i] : pbit;
      gin = 3'($urandom);
      cyc();
      cfg_valid = 1'b0;
      if (busy) chk("frozen", out, frz);
    end
  endtask

  task automatic sweep(input logic [7:0] exp_tbl);
    logic prev;
    for (int v = 0; v < 8; v++) begin
      prev = out;
      gin = 3'(v);
      cyc();
      chk($sformatf("lat_hold_in%0d", v), out, prev);
      cyc();
      chk($sformatf("lat_new_in%0d", v), out, exp_tbl[v]);
      repeat (2) cyc();
      chk($sformatf("sweep_in%0d", v), out, exp_tbl[v]);
    end
  endtask

  initial begin
    int d0;
    logic [7:0] t;
    rst = 1'b1;
    repeat (2) cyc();
    chk("rst_out", out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    gin = 3'd0;
    cyc();

    sweep(RST_TBL);

    // single-cycle glitch 0 -> 3 -> 0
    gin = 3'd0;
    repeat (4) cyc();
    gin = 3'd3;
    cyc();
    gin = 3'd0;
    repeat (4) begin cyc(); chk("glitch", out, 1'b0); end

    // XOR3 load
    d0 = done_cnt;
    load_bits(8'h96, NB, 1'b0, 3);
    cyc(); cyc();
    chk("xor_done_once", 1'(done_cnt - d0 == 1), 1'b1);
    sweep(8'h96);

    // restart after 5 bits, then full 0xFF load
    load_bits(8'h00, 5, 1'b0, 1);
    load_bits(8'hFF, NB, 1'b0, 2);
    cyc(); cyc();
    sweep(8'hFF);

    // reset in the middle of a load
    load_bits(8'h96, 4, 1'b0, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out", out, 1'b0);
    gin = 3'd0;
    cyc();
    sweep(RST_TBL);

`ifdef PROG_LOGIC_PARITY_EN
    load_bits(8'h96, NB, 1'b0, 1);
    cyc(); cyc();
    sweep(8'h96);
    d0 = done_cnt;
    load_bits(8'hFF, NB, 1'b1, 1);
    cyc(); cyc();
    chk("par_no_done", 1'(done_cnt == d0), 1'b1);
    sweep(8'h96);
`endif

    // random tables and traffic; stray cfg_valid in RUN must be ignored
    for (int r = 0; r < 4; r++) begin
      t = 8'($urandom);
      load_bits(t, NB, ^t, 3);
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 2) == 0) gin = 3'($urandom);
        cfg_valid = 1'($urandom);
        cfg_bit   = 1'($urandom);
        cyc();
      end
      cfg_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
